render_dbuf: RTL and testbench



---
 rtl/render_dbuf.sv | 184 ++++++++++++++++++
 tb/tb_render_dbuf.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_dbuf.sv
// Double-buffered pixel renderer: Avalon-MM register file, one-pixel-per-cycle fill
// engine drawing into the back buffer, and a registered scanout port on the front buffer.
module render_dbuf #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int CW     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      slave_address,
  input  logic            slave_read,
  input  logic            slave_write,
  input  logic [31:0]     slave_writedata,
  output logic [31:0]     slave_readdata,
  output logic            slave_waitrequest,
  input  logic            frame_start,
  input  logic [9:0]      scan_x,
  input  logic [8:0]      scan_y,
  output logic [3*CW-1:0] scan_rgb
);

  localparam int PW   = 3 * CW;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [9:0] W_M1 = 10'(WIDTH - 1);
  localparam logic [8:0] H_M1 = 9'(HEIGHT - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [PW-1:0] buf0 [NPIX];
  logic [PW-1:0] buf1 [NPIX];

  logic          front, swap_pending;
  logic [31:0]   frames;
  logic [9:0]    x0_r, x1_r;
  logic [8:0]    y0_r, y1_r;
  logic [PW-1:0] color_r;
  logic [0:0]    state;

  logic [9:0]    fx0, fx, fx1;
  logic [8:0]    fy, fy1;
  logic [PW-1:0] fcol;

  logic          vld_p1;
  logic [AW-1:0] plot_addr_p1;
  logic [PW-1:0] plot_col_p1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;

  function automatic logic [9:0] sat_x(input logic [9:0] v);
    return (v > W_M1) ? W_M1 : v;
  endfunction

  function automatic logic [8:0] sat_y(input logic [8:0] v);
    return (v > H_M1) ? H_M1 : v;
  endfunction

  function automatic logic [AW-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  logic busy, acc_wr, cmd_acc, cmd_plot, cmd_fill, cmd_clear;
  logic [9:0] clip_x1;
  logic [8:0] clip_y1;
  logic in_frame, rect_ok;

  assign busy      = (state == S_FILL);
  assign acc_wr    = slave_write && !busy;
  assign cmd_acc   = acc_wr && (slave_address == 4'd4);
  assign cmd_plot  = cmd_acc && (slave_writedata == 32'd0);
  assign cmd_fill  = cmd_acc && (slave_writedata == 32'd1);
  assign cmd_clear = cmd_acc && (slave_writedata == 32'd2);
  assign clip_x1   = sat_x(x1_r);
  assign clip_y1   = sat_y(y1_r);
  assign in_frame  = (x0_r <= W_M1) && (y0_r <= H_M1);
  assign rect_ok   = in_frame && (x0_r <= clip_x1) && (y0_r <= clip_y1);

  assign slave_waitrequest = (slave_read | slave_write) & busy;

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = {29'b0, front, busy, swap_pending};
        4'd1:    slave_readdata = {7'b0, y0_r, 6'b0, x0_r};
        4'd2:    slave_readdata = {7'b0, y1_r, 6'b0, x1_r};
        4'd3:    slave_readdata = {{(32-PW){1'b0}}, color_r};
        4'd5:    slave_readdata = frames;
        default: slave_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      frames       <= '0;
      x0_r         <= '0;
      y0_r         <= '0;
      x1_r         <= '0;
      y1_r         <= '0;
      color_r      <= '0;
      state        <= S_IDLE;
      vld_p1       <= 1'b0;
    end else begin
      if (acc_wr) begin
        case (slave_address)
          4'd1: begin x0_r <= slave_writedata[9:0]; y0_r <= slave_writedata[24:16]; end
          4'd2: begin x1_r <= slave_writedata[9:0]; y1_r <= slave_writedata[24:16]; end
          4'd3: color_r <= slave_writedata[PW-1:0];
          default: ;
        endcase
      end
      // A swap uses the pending flag from before this edge, so a same-cycle CTRL write waits a frame.
      if (frame_start && swap_pending && !busy) begin
        front        <= ~front;
        swap_pending <= 1'b0;
        frames       <= frames + 32'd1;
      end else if (acc_wr && slave_address == 4'd0 && slave_writedata[0]) begin
        swap_pending <= 1'b1;
      end
      vld_p1 <= cmd_plot && in_frame;
      case (state)
        S_IDLE:  if (cmd_clear || (cmd_fill && rect_ok)) state <= S_FILL;
        default: if (fx == fx1 && fy == fy1) state <= S_IDLE;
      endcase
    end
  end

  // Fill cursor and pending plot are data: gated by state/vld_p1, never reset.
  always_ff @(posedge clk) begin
    if (cmd_acc) begin
      fcol <= color_r;
      if (cmd_clear) begin
        fx0 <= '0; fx <= '0; fy <= '0; fx1 <= W_M1; fy1 <= H_M1;
      end else begin
        fx0 <= x0_r; fx <= x0_r; fy <= y0_r; fx1 <= clip_x1; fy1 <= clip_y1;
      end
    end else if (busy) begin
      if (fx == fx1) begin
        fx <= fx0;
        fy <= fy + 9'd1;
      end else begin
        fx <= fx + 10'd1;
      end
    end
    plot_addr_p1 <= pix_addr(x0_r, y0_r);
    plot_col_p1  <= color_r;
  end

  always_comb begin
    wr_en   = vld_p1;
    wr_addr = plot_addr_p1;
    wr_data = plot_col_p1;
    if (busy) begin
      wr_en   = 1'b1;
      wr_addr = pix_addr(fx, fy);
      wr_data = fcol;
    end
  end

  // Back buffer is always the one front does not select.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front) buf0[wr_addr] <= wr_data;
      else       buf1[wr_addr] <= wr_data;
    end
  end

  // ---- scanout stage p1: registered front-buffer read ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_rgb <= '0;
    end else if (scan_x <= W_M1 && scan_y <= H_M1) begin
      scan_rgb <= front ? buf1[pix_addr(scan_x, scan_y)] : buf0[pix_addr(scan_x, scan_y)];
    end else begin
      scan_rgb <= '0;
    end
  end

endmodule

// File: tb/tb_render_dbuf.sv
// Randomized scoreboard bench for render_dbuf on a reduced frame, with a
// pixel-array reference model of both buffers and the swap/register state.
module tb_render_dbuf;
  localparam int W = 40, H = 24, CW = 4, PW = 12, NPIX = W * H, TIMEOUT = 4000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [3:0]    slave_address = '0;
  logic          slave_read = 1'b0, slave_write = 1'b0;
  logic [31:0]   slave_writedata = '0;
  logic [31:0]   slave_readdata;
  logic          slave_waitrequest;
  logic          frame_start = 1'b0;
  logic [9:0]    scan_x = '0;
  logic [8:0]    scan_y = '0;
  logic [PW-1:0] scan_rgb;

  always #5 clk = ~clk;

  render_dbuf #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .slave_waitrequest(slave_waitrequest), .frame_start(frame_start),
    .scan_x(scan_x), .scan_y(scan_y), .scan_rgb(scan_rgb)
  );

  int n_checks = 0, n_errors = 0;
  logic [31:0]   rd_q[$];
  logic [PW-1:0] scan_q[$];
  logic          scan_req = 1'b0, scan_chk = 1'b0;

  logic [PW-1:0] mem [2][NPIX];
  logic [PW-1:0] saved [NPIX];
  logic          front_m = 1'b0, pend_m = 1'b0;
  logic [31:0]   frames_m = '0;
  int            rx0 = 0, ry0 = 0, rx1 = 0, ry1 = 0, last_cnt = 0;
  logic [PW-1:0] rcol = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] xy(input int x, input int y);
    return {7'b0, 9'(y), 6'b0, 10'(x)};
  endfunction

  function automatic logic [31:0] ctrl_exp();
    return {29'b0, front_m, 1'b0, pend_m};
  endfunction

  // Draw an inclusive rectangle into the back buffer, clipped to the frame; returns pixel count.
  function automatic int m_draw(input int ax0, input int ay0, input int ax1, input int ay1,
                                input logic [PW-1:0] c);
    int n = 0;
    int b = (front_m == 1'b0) ? 1 : 0;
    for (int y = ay0; y <= ay1 && y < H; y++)
      for (int x = ax0; x <= ax1 && x < W; x++) begin
        mem[b][y * W + x] = c;
        n++;
      end
    return n;
  endfunction

  function automatic void m_swap();
    front_m  = ~front_m;
    pend_m   = 1'b0;
    frames_m = frames_m + 32'd1;
  endfunction

  always @(posedge clk) scan_chk <= scan_req;

  always @(negedge clk) begin
    if (slave_read && !slave_waitrequest) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL readdata_unexpected: got %0h, required no read", slave_readdata);
      end else chk("readdata", slave_readdata, rd_q.pop_front());
    end
    if (scan_chk) begin
      if (scan_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scan_unexpected: got %0h, required no scan", scan_rgb);
      end else chk("scan_rgb", 32'(scan_rgb), 32'(scan_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input bit fs, output int stall);
    slave_address = a; slave_writedata = d; slave_write = 1'b1; frame_start = fs; stall = 0;
    @(negedge clk);
    while (slave_waitrequest && stall < TIMEOUT) begin stall++; @(negedge clk); end
    if (stall >= TIMEOUT) begin
      n_checks++; n_errors++;
      $display("FAIL write_timeout: addr %0d stalled %0d cycles, required release", a, stall);
    end
    @(posedge clk); #1;
    slave_write = 1'b0; frame_start = 1'b0;
    if (fs && pend_m) m_swap();
    else if (a == 4'd0 && d[0]) pend_m = 1'b1;
    last_cnt = 0;
    case (a)
      4'd1: begin rx0 = int'(d[9:0]); ry0 = int'(d[24:16]); end
      4'd2: begin rx1 = int'(d[9:0]); ry1 = int'(d[24:16]); end
      4'd3: rcol = d[PW-1:0];
      4'd4: begin
        if (d == 32'd0) void'(m_draw(rx0, ry0, rx0, ry0, rcol));
        else if (d == 32'd1) last_cnt = m_draw(rx0, ry0, rx1, ry1, rcol);
        else if (d == 32'd2) last_cnt = m_draw(0, 0, W - 1, H - 1, rcol);
      end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, output int stall);
    logic [31:0] drop;
    rd_q.push_back(exp);
    slave_address = a; slave_read = 1'b1; stall = 0;
    @(negedge clk);
    while (slave_waitrequest && stall < TIMEOUT) begin stall++; @(negedge clk); end
    if (stall >= TIMEOUT) begin
      n_checks++; n_errors++;
      $display("FAIL read_timeout: addr %0d stalled %0d cycles, required release", a, stall);
      drop = rd_q.pop_front();
    end
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  task automatic scan(input int x, input int y);
    scan_x = 10'(x); scan_y = 9'(y); scan_req = 1'b1;
    scan_q.push_back((x < W && y < H) ? mem[front_m][y * W + x] : '0);
    @(posedge clk); #1;
    scan_req = 1'b0;
  endtask

  task automatic sweep();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) scan(x, y);
  endtask

  task automatic pulse_fs(input bit busy_now);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    if (!busy_now && pend_m) m_swap();
  endtask

  task automatic swap_now();
    int st;
    wr(4'd0, 32'd1, 1'b0, st);
    pulse_fs(1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, r, x0, y0, b;
    idle(3);
    chk("rst_scan_rgb", 32'(scan_rgb), 32'd0);
    chk("rst_readdata", slave_readdata, 32'd0);
    chk("rst_waitrequest", 32'(slave_waitrequest), 32'd0);
    rst_n = 1'b1;
    idle(1);
    rd(4'd0, 32'd0, st); rd(4'd5, 32'd0, st); rd(4'd1, 32'd0, st); rd(4'd3, 32'd0, st);

    // Bring both buffers to known contents.
    wr(4'd3, 32'h111, 1'b0, st); wr(4'd4, 32'd2, 1'b0, st);
    rd(4'd0, ctrl_exp(), st); chk("clear_busy_len", st, NPIX);
    swap_now();
    wr(4'd3, 32'h222, 1'b0, st); wr(4'd4, 32'd2, 1'b0, st);
    rd(4'd0, ctrl_exp(), st);
    swap_now();
    rd(4'd5, frames_m, st);

    // Reset in the middle of a clear: first 100 pixels written, then everything stops.
    b = (front_m == 1'b0) ? 1 : 0;
    for (int i = 0; i < NPIX; i++) saved[i] = mem[b][i];
    wr(4'd3, 32'h333, 1'b0, st); wr(4'd4, 32'd2, 1'b0, st);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    rd_q.push_back(32'd0);
    slave_address = 4'd0; slave_read = 1'b1;
    #1 chk("midfill_rst_scan_rgb", 32'(scan_rgb), 32'd0);
    @(posedge clk); #1 slave_read = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < NPIX; i++) mem[b][i] = (i < 100) ? 12'h333 : saved[i];
    front_m = 1'b0; pend_m = 1'b0; frames_m = '0;
    rx0 = 0; ry0 = 0; rx1 = 0; ry1 = 0; rcol = '0;
    rd(4'd0, 32'd0, st); rd(4'd5, 32'd0, st); rd(4'd3, 32'd0, st);
    swap_now();
    sweep();
    rd(4'd5, frames_m, st);

    // Single plot becomes visible only after the swap.
    wr(4'd1, xy(5, 7), 1'b0, st); wr(4'd3, 32'hF00, 1'b0, st); wr(4'd4, 32'd0, 1'b0, st);
    rd(4'd0, ctrl_exp(), st); chk("plot_busy_len", st, 0);
    scan(5, 7);
    swap_now();
    scan(5, 7); scan(6, 7);
    rd(4'd5, frames_m, st); rd(4'd0, ctrl_exp(), st);

    // 4x2 fill; a CMD write during busy stalls exactly the fill length.
    wr(4'd1, xy(10, 10), 1'b0, st); wr(4'd2, xy(13, 11), 1'b0, st);
    wr(4'd3, 32'h0A5, 1'b0, st); wr(4'd4, 32'd1, 1'b0, st);
    wr(4'd4, 32'd7, 1'b0, st); chk("fill_stall_len", st, 8);
    rd(4'd2, xy(13, 11), st);
    swap_now();
    for (int y = 10; y <= 11; y++) for (int x = 9; x <= 14; x++) scan(x, y);

    // Clipping and empty commands.
    wr(4'd1, xy(W - 2, H - 2), 1'b0, st); wr(4'd2, xy(W + 16, H + 12), 1'b0, st);
    wr(4'd3, 32'h5A5, 1'b0, st); wr(4'd4, 32'd1, 1'b0, st);
    rd(4'd0, ctrl_exp(), st); chk("clip_busy_len", st, 4);
    wr(4'd1, xy(20, 5), 1'b0, st); wr(4'd2, xy(10, 9), 1'b0, st); wr(4'd4, 32'd1, 1'b0, st);
    rd(4'd0, ctrl_exp(), st); chk("empty_busy_len", st, 0);
    wr(4'd1, xy(W, 0), 1'b0, st); wr(4'd3, 32'hFFF, 1'b0, st); wr(4'd4, 32'd0, 1'b0, st);
    wr(4'd1, xy(0, H), 1'b0, st); wr(4'd4, 32'd0, 1'b0, st);
    rd(4'd0, ctrl_exp(), st); chk("oob_plot_busy_len", st, 0);
    swap_now();
    sweep();

    // Swap requested before a clear is deferred past the frame_start seen while busy.
    wr(4'd0, 32'd1, 1'b0, st); wr(4'd3, 32'h0F0, 1'b0, st); wr(4'd4, 32'd2, 1'b0, st);
    idle(100);
    pulse_fs(1'b1);
    rd(4'd0, ctrl_exp(), st);
    pulse_fs(1'b0);
    rd(4'd5, frames_m, st); rd(4'd0, ctrl_exp(), st);
    sweep();

    // CTRL write coinciding with frame_start swaps only on the next frame_start.
    wr(4'd0, 32'd1, 1'b1, st);
    rd(4'd0, ctrl_exp(), st);
    pulse_fs(1'b0);
    rd(4'd0, ctrl_exp(), st); rd(4'd5, frames_m, st);

    // CMD plot together with a swapping frame_start lands in the new back buffer.
    wr(4'd0, 32'd1, 1'b0, st); wr(4'd1, xy(3, 3), 1'b0, st); wr(4'd3, 32'hABC, 1'b0, st);
    wr(4'd4, 32'd0, 1'b1, st);
    scan(3, 3); scan(400, 10); scan(3, 300);
    rd(4'd5, frames_m, st);
    swap_now();
    scan(3, 3);

    // Randomized command mix against the model.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: begin
          wr(4'd1, xy($urandom_range(0, W + 5), $urandom_range(0, H + 5)), 1'b0, st);
          wr(4'd3, 32'($urandom_range(0, 4095)), 1'b0, st);
          wr(4'd4, 32'd0, 1'b0, st);
          rd(4'd0, ctrl_exp(), st); chk("rand_plot_busy", st, 0);
        end
        1, 2: begin
          x0 = $urandom_range(0, W + 5); y0 = $urandom_range(0, H + 5);
          wr(4'd1, xy(x0, y0), 1'b0, st);
          wr(4'd2, xy($urandom_range(0, W + 5), $urandom_range(0, H + 5)), 1'b0, st);
          wr(4'd3, 32'($urandom_range(0, 4095)), 1'b0, st);
          wr(4'd4, 32'd1, 1'b0, st);
          rd(4'd0, ctrl_exp(), st); chk("rand_fill_busy", st, last_cnt);
        end
        3: swap_now();
        4: for (int k = 0; k < 10; k++) scan($urandom_range(0, 1023), $urandom_range(0, 511));
        default: begin
          x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 511);
          wr(4'd1, xy(x0, y0), 1'b0, st);
          rd(4'd1, xy(x0, y0), st);
        end
      endcase
      for (int k = 0; k < 6; k++) scan($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    end
    sweep();
    swap_now();
    sweep();
    rd(4'd5, frames_m, st);

    idle(3);
    chk("queues_drained", 32'(rd_q.size() + scan_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
